hamming_serial_rx: RTL and testbench

Receive-side front end for the Hamming(7,4) datapath. Deserializes a bit-serial stream of 7-bit codewords (positions 7..1 = i3,i2,i1,c2,i0,c1,c0) and computes the syndrome. Corrects any single-bit error and presents the 4-bit data word with a valid/ready handshake to the downstream consumer (LED/display logic). Also tracks a saturating count of corrected words and drops stalled partial frames on an inter-bit timeout.

---
 rtl/hamming_pkg.sv | 14 +
 rtl/hamming74_correct.sv | 16 +
 rtl/hamming_serial_rx.sv | 96 +++++++++
 tb/tb_hamming_serial_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) codeword layout, types and receiver states.
package hamming_pkg;
    localparam int POS_C0 = 1;
    localparam int POS_C1 = 2;
    localparam int POS_I0 = 3;
    localparam int POS_C2 = 4;
    localparam int POS_I1 = 5;
    localparam int POS_I2 = 6;
    localparam int POS_I3 = 7;
    localparam int SYN_W  = 3;
    typedef logic [6:0] codeword_t;
    typedef logic [3:0] data_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, HOLD} rx_state_t;
endpackage

// File: rtl/hamming74_correct.sv
// hamming74_correct: combinational syndrome and single-bit correction of a 7-bit codeword.
module hamming74_correct
    import hamming_pkg::*;
(
    input  codeword_t        i_cw,
    output data_t            o_data,
    output logic [SYN_W-1:0] o_syn
);
    codeword_t w_fix;
    assign o_syn[0] = i_cw[POS_C0-1] ^ i_cw[POS_I0-1] ^ i_cw[POS_I1-1] ^ i_cw[POS_I3-1];
    assign o_syn[1] = i_cw[POS_C1-1] ^ i_cw[POS_I0-1] ^ i_cw[POS_I2-1] ^ i_cw[POS_I3-1];
    assign o_syn[2] = i_cw[POS_C2-1] ^ i_cw[POS_I1-1] ^ i_cw[POS_I2-1] ^ i_cw[POS_I3-1];
    // syndrome value is the 1-based position of the flipped bit
    assign w_fix  = i_cw ^ ((o_syn == '0) ? '0 : codeword_t'(1) << (o_syn - 3'd1));
    assign o_data = {w_fix[POS_I3-1], w_fix[POS_I2-1], w_fix[POS_I1-1], w_fix[POS_I0-1]};
endmodule

// File: rtl/hamming_serial_rx.sv
// hamming_serial_rx: deserializes 7-bit Hamming codewords, corrects single-bit errors,
// and hands the data nibble downstream over a valid/ready slot with an inter-bit timeout.
module hamming_serial_rx
    import hamming_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 8,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [3:0]       data_out,
    output logic [2:0]       syndrome,
    output logic             err_corrected,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] corr_count,
    output logic             timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    rx_state_t        r_state, w_next;
    logic [2:0]       r_cnt;
    codeword_t        r_sr, w_sr_next;
    logic [TW-1:0]    r_timer;
    logic             w_xfer, w_free, w_load, w_to;
    data_t            w_data;
    logic [SYN_W-1:0] w_syn;

    hamming74_correct u_corr (.i_cw(r_sr), .o_data(w_data), .o_syn(w_syn));

    assign bit_ready = (r_state == IDLE) || (r_state == SHIFT);
    assign w_xfer    = bit_valid & bit_ready;
    assign w_free    = !out_valid || out_ready;
    assign w_load    = ((r_state == DECODE) || (r_state == HOLD)) && w_free;
    assign w_to      = (r_state == SHIFT) && !w_xfer && (r_timer == TW'(TIMEOUT_CYC - 1));
    assign w_sr_next = MSB_FIRST ? {r_sr[5:0], bit_in} : {bit_in, r_sr[6:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   w_next = w_xfer ? SHIFT : IDLE;
            SHIFT:  w_next = (w_xfer && r_cnt == 3'd6) ? DECODE : (w_to ? IDLE : SHIFT);
            DECODE: w_next = w_free ? IDLE : HOLD;
            HOLD:   w_next = w_free ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            r_timer <= '0;
        end else begin
            if (w_xfer) begin
                r_sr  <= w_sr_next;
                r_cnt <= (r_cnt == 3'd6) ? 3'd0 : r_cnt + 3'd1;
            end else if (w_to) begin
                r_cnt <= '0;
            end
            r_timer <= (w_xfer || w_to || r_state != SHIFT) ? '0 : r_timer + 1'b1;
        end
    end

    // The shift register is frozen in DECODE/HOLD, so the corrector output stays valid there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out      <= '0;
            syndrome      <= '0;
            err_corrected <= 1'b0;
            out_valid     <= 1'b0;
            corr_count    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= w_to;
            if (w_load) begin
                data_out      <= w_data;
                syndrome      <= w_syn;
                err_corrected <= (w_syn != '0);
                out_valid     <= 1'b1;
                if (w_syn != '0 && corr_count != '1) corr_count <= corr_count + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb_hamming_serial_rx: directed checks of deserialization, correction, handshake,
// timeout, reset, counter saturation and LSB-first ordering.
module tb_hamming_serial_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bi[3], bv[3], ordy[3], br[3], ov[3], te[3], er[3];
    logic [3:0] d[3];
    logic [2:0] s[3];
    logic [7:0] cc[3];
    logic [7:0] cc0, cc2;
    logic [1:0] cc1;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hamming_serial_rx #(.TIMEOUT_CYC(16)) u0 (
        .clk(clk), .rst(rst), .bit_in(bi[0]), .bit_valid(bv[0]), .bit_ready(br[0]),
        .data_out(d[0]), .syndrome(s[0]), .err_corrected(er[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .corr_count(cc0), .timeout_err(te[0]));
    hamming_serial_rx #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .bit_in(bi[1]), .bit_valid(bv[1]), .bit_ready(br[1]),
        .data_out(d[1]), .syndrome(s[1]), .err_corrected(er[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .corr_count(cc1), .timeout_err(te[1]));
    hamming_serial_rx #(.MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst(rst), .bit_in(bi[2]), .bit_valid(bv[2]), .bit_ready(br[2]),
        .data_out(d[2]), .syndrome(s[2]), .err_corrected(er[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .corr_count(cc2), .timeout_err(te[2]));

    assign cc[0] = cc0;
    assign cc[1] = {6'd0, cc1};
    assign cc[2] = cc2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int k, input logic b);
        if (br[k] !== 1'b1) begin n_fail++; $display("FAIL send_bit_ready[%0d] got %b exp 1", k, br[k]); end
        n_cmp++;
        bi[k] = b;
        bv[k] = 1'b1;
        tick();
        bv[k] = 1'b0;
    endtask

    task automatic send_frame(input int k, input logic [6:0] w, input bit msb);
        for (int i = 0; i < 7; i++) send_bit(k, msb ? w[6-i] : w[i]);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", ov[0]); end
        n_cmp++;
        if (d[0] !== 4'd0 || s[0] !== 3'd0 || er[0] !== 1'b0) begin n_fail++; $display("FAIL rst_data got %b/%b/%b exp 0/0/0", d[0], s[0], er[0]); end
        n_cmp++;
        if (cc[0] !== 8'd0 || te[0] !== 1'b0) begin n_fail++; $display("FAIL rst_cnt got %0d/%b exp 0/0", cc[0], te[0]); end
        n_cmp++;
        rst = 1'b0;
        tick();
        if (br[0] !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", br[0]); end
        n_cmp++;
    endtask

    task automatic test_single();
        ordy[0] = 1'b1;
        send_frame(0, 7'b1110110, 1'b1);
        if (ov[0] !== 1'b0 || br[0] !== 1'b0) begin n_fail++; $display("FAIL single_decode got v=%b r=%b exp v=0 r=0", ov[0], br[0]); end
        n_cmp++;
        tick();
        if (ov[0] !== 1'b1 || d[0] !== 4'b1101 || s[0] !== 3'b101 || er[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_out got v=%b d=%b s=%b e=%b exp v=1 d=1101 s=101 e=1", ov[0], d[0], s[0], er[0]);
        end
        n_cmp++;
        if (cc[0] !== 8'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", cc[0]); end
        n_cmp++;
        tick();
        if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL single_consume got %b exp 0", ov[0]); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        ordy[0] = 1'b0;
        send_frame(0, 7'b0010011, 1'b1);
        tick();
        if (ov[0] !== 1'b1 || d[0] !== 4'b0110 || s[0] !== 3'b110) begin
            n_fail++; $display("FAIL b2b_first got v=%b d=%b s=%b exp v=1 d=0110 s=110", ov[0], d[0], s[0]);
        end
        n_cmp++;
        send_frame(0, 7'b1100110, 1'b1);
        tick();
        tick();
        tick();
        if (br[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_ready got %b exp 0", br[0]); end
        n_cmp++;
        if (ov[0] !== 1'b1 || d[0] !== 4'b0110 || s[0] !== 3'b110 || er[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_hold_stable got v=%b d=%b s=%b e=%b exp v=1 d=0110 s=110 e=1", ov[0], d[0], s[0], er[0]);
        end
        n_cmp++;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        if (ov[0] !== 1'b1 || d[0] !== 4'b1101 || s[0] !== 3'b000 || er[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got v=%b d=%b s=%b e=%b exp v=1 d=1101 s=000 e=0", ov[0], d[0], s[0], er[0]);
        end
        n_cmp++;
        if (cc[0] !== 8'd2) begin n_fail++; $display("FAIL b2b_cnt got %0d exp 2", cc[0]); end
        n_cmp++;
        if (br[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got %b exp 1", br[0]); end
        n_cmp++;
        ordy[0] = 1'b1;
        tick();
        if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_consume got %b exp 0", ov[0]); end
        n_cmp++;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int valids = 0;
        ordy[0] = 1'b1;
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        for (int i = 0; i < 21; i++) begin
            tick();
            if (te[0] === 1'b1) pulses++;
            if (ov[0] === 1'b1) valids++;
        end
        if (pulses != 1) begin n_fail++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
        n_cmp++;
        if (valids != 0) begin n_fail++; $display("FAIL timeout_valid got %0d exp 0", valids); end
        n_cmp++;
        send_frame(0, 7'b1010000, 1'b1);
        tick();
        if (ov[0] !== 1'b1 || d[0] !== 4'b1010 || s[0] !== 3'b010 || er[0] !== 1'b1) begin
            n_fail++; $display("FAIL timeout_next got v=%b d=%b s=%b e=%b exp v=1 d=1010 s=010 e=1", ov[0], d[0], s[0], er[0]);
        end
        n_cmp++;
        if (cc[0] !== 8'd3) begin n_fail++; $display("FAIL timeout_cnt got %0d exp 3", cc[0]); end
        n_cmp++;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        rst = 1'b1;
        #1;
        if (ov[0] !== 1'b0 || d[0] !== 4'd0 || s[0] !== 3'd0 || er[0] !== 1'b0 || cc[0] !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_frame got v=%b d=%b s=%b e=%b c=%0d exp all 0", ov[0], d[0], s[0], er[0], cc[0]);
        end
        n_cmp++;
        tick();
        rst = 1'b0;
        tick();
        ordy[0] = 1'b0;
        send_frame(0, 7'b0010011, 1'b1);
        tick();
        send_frame(0, 7'b1100110, 1'b1);
        tick();
        tick();
        if (br[0] !== 1'b0 || ov[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_hold got r=%b v=%b exp r=0 v=1", br[0], ov[0]); end
        n_cmp++;
        rst = 1'b1;
        #1;
        if (ov[0] !== 1'b0 || d[0] !== 4'd0 || s[0] !== 3'd0 || er[0] !== 1'b0 || cc[0] !== 8'd0 || te[0] !== 1'b0) begin
            n_fail++; $display("FAIL rsthold_out got v=%b d=%b s=%b e=%b c=%0d t=%b exp all 0", ov[0], d[0], s[0], er[0], cc[0], te[0]);
        end
        n_cmp++;
        if (br[0] !== 1'b1) begin n_fail++; $display("FAIL rsthold_ready got %b exp 1", br[0]); end
        n_cmp++;
        tick();
        rst = 1'b0;
        tick();
        ordy[0] = 1'b1;
        send_frame(0, 7'b0000000, 1'b1);
        tick();
        if (ov[0] !== 1'b1 || d[0] !== 4'b0000 || s[0] !== 3'b000 || er[0] !== 1'b0 || te[0] !== 1'b0) begin
            n_fail++; $display("FAIL rst_after got v=%b d=%b s=%b e=%b t=%b exp v=1 d=0000 s=000 e=0 t=0", ov[0], d[0], s[0], er[0], te[0]);
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_saturate();
        ordy[1] = 1'b1;
        for (int f = 0; f < 5; f++) begin
            send_frame(1, 7'b1110110, 1'b1);
            tick();
            if (ov[1] !== 1'b1 || cc[1] !== 8'((f < 3) ? f + 1 : 3)) begin
                n_fail++; $display("FAIL sat_cnt[%0d] got v=%b c=%0d exp v=1 c=%0d", f, ov[1], cc[1], (f < 3) ? f + 1 : 3);
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_lsb_first();
        ordy[2] = 1'b1;
        send_frame(2, 7'b1110110, 1'b0);
        tick();
        if (ov[2] !== 1'b1 || d[2] !== 4'b1101 || s[2] !== 3'b101 || er[2] !== 1'b1) begin
            n_fail++; $display("FAIL lsb_out got v=%b d=%b s=%b e=%b exp v=1 d=1101 s=101 e=1", ov[2], d[2], s[2], er[2]);
        end
        n_cmp++;
        tick();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            bi[k] = 1'b0;
            bv[k] = 1'b0;
            ordy[k] = 1'b0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_saturate();
        test_lsb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
